// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
//
// Signals:
//   start   : request a conversion of bin (driven by master)
//   bin     : unsigned binary value to convert (driven by master)
//   busy    : a conversion is in flight, start is ignored (driven by slave)
//   done    : one-cycle pulse, bcd/ndigits hold a new result (driven by slave)
//   bcd     : packed BCD result, units digit in the low nibble (driven by slave)
//   ndigits : number of significant decimal digits, 1..DIGITS (driven by slave)
//
// Modports:
//   master : the block requesting conversions (e.g. the sensor decoder side)
//   slave  : the converter itself
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                         start;
    logic [BIN_W-1:0]             bin;
    logic                         busy;
    logic                         done;
    logic [4*DIGITS-1:0]          bcd;
    logic [$clog2(DIGITS+1)-1:0]  ndigits;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ndigits
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ndigits
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock. Feeds the LCD character driver with packed BCD
// digits plus a significant-digit count for leading-zero blanking.
//
// Parameters:
//   BIN_W  : input binary width, 1..32
//   DIGITS : number of BCD output digits, large enough for 2**BIN_W-1
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : bin2bcd_seq_if slave modport (start/bin in, busy/done/bcd/ndigits out)
//
// Timing: start accepted at edge k, bits shifted on edges k+1..k+BIN_W, result
// and a one-cycle done pulse appear at edge k+BIN_W+1, together with busy
// dropping. A start seen in the done cycle is accepted immediately.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam int ND_W  = $clog2(DIGITS + 1);

    // Decimal digits needed for the largest BIN_W-bit value; this equals
    // ceil(BIN_W*log10(2)) because 2**BIN_W is never a power of ten.
    function automatic int min_digits(input int w);
        longint unsigned m;
        int              n;
        m = (64'd1 << w) - 64'd1;
        n = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    // Refuse to elaborate with an input width or digit count that could
    // silently truncate the result.
    generate
        if (BIN_W < 1 || BIN_W > 32) begin : g_bad_width
            $error("bin2bcd_seq: BIN_W must be in 1..32");
        end
        else if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
            $error("bin2bcd_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_t;

    state_t              state;
    logic [BIN_W-1:0]    sreg;
    logic [BCD_W-1:0]    work;
    logic [BCD_W-1:0]    work_adj;
    logic [CNT_W-1:0]    cnt;
    logic                busy_q;
    logic                done_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [ND_W-1:0]     nd_q;
    logic [ND_W-1:0]     nd_next;

    // Add-3 correction: every nibble of 5 or more gets +3 before the shift,
    // all nibbles judged on their pre-adjust values. With a legal DIGITS the
    // top nibble never carries out, so 4-bit wraparound is harmless.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    // Significant-digit count: position of the highest nonzero nibble plus
    // one, with an all-zero result still reporting a single digit.
    always_comb begin
        nd_next = ND_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] != 4'd0) begin
                nd_next = ND_W'(i + 1);
            end
        end
    end

    // Conversion FSM with registered handshake outputs. done defaults low
    // every cycle so it can only ever be a single-cycle pulse from OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sreg   <= '0;
            work   <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
            nd_q   <= ND_W'(1);
        end
        else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sreg   <= bus.bin;
                        work   <= '0;
                        cnt    <= CNT_W'(BIN_W);
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= {work_adj[BCD_W-2:0], sreg[BIN_W-1]};
                    sreg <= sreg << 1;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    bcd_q  <= work;
                    nd_q   <= nd_next;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd     = bcd_q;
    assign bus.ndigits = nd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq. Two instances share clk/rst: the
// default 8-bit/3-digit build and a 16-bit/5-digit build. Expected results
// come from hand-written vectors and a decimal reference model built on
// plain integer division.
module tb_bin2bcd_seq;

    logic clk;
    logic rst;

    int checks;
    int failures;
    int done8Count;

    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) if8 ();
    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) ifw ();

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dutw (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every done pulse of the default instance for the sweep check.
    always @(negedge clk) begin
        if (if8.done) done8Count++;
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        int          nd;
    } vec_t;

    // Decimal reference: peel off base-10 digits with plain arithmetic.
    function automatic logic [31:0] refBcd(input int unsigned v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int refDigits(input int unsigned v);
        int n;
        n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge. Raises start for one edge, then counts the
    // edges after acceptance until done is seen (bounded), and how many of
    // those samples showed busy high. Returns at the done-cycle negedge so a
    // following call starts back-to-back.
    task automatic applyStimulus(input logic [7:0] v, output int lat,
                                 output int busyCnt);
        if8.start = 1'b1;
        if8.bin   = v;
        @(negedge clk);
        if8.start = 1'b0;
        lat     = 0;
        busyCnt = 0;
        while (!if8.done && lat < 40) begin
            if (if8.busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyWide(input logic [15:0] v, output int lat);
        ifw.start = 1'b1;
        ifw.bin   = v;
        @(negedge clk);
        ifw.start = 1'b0;
        lat = 0;
        while (!ifw.done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   perm[256];
        int   lat;
        int   busyCnt;
        int   n;
        int   dn;
        int   snap;
        logic [15:0] wv;

        checks     = 0;
        failures   = 0;
        done8Count = 0;

        vecs[0] = '{8'd255, 12'h255, 3};
        vecs[1] = '{8'd0,   12'h000, 1};
        vecs[2] = '{8'd7,   12'h007, 1};
        vecs[3] = '{8'd40,  12'h040, 2};
        vecs[4] = '{8'd99,  12'h099, 2};
        vecs[5] = '{8'd100, 12'h100, 3};
        vecs[6] = '{8'd10,  12'h010, 2};
        vecs[7] = '{8'd9,   12'h009, 1};

        if8.start = 1'b0;
        if8.bin   = '0;
        ifw.start = 1'b0;
        ifw.bin   = '0;
        rst       = 1'b1;

        // Reset state of both instances.
        @(negedge clk);
        checkOutput("rst_busy",  32'(if8.busy),    32'd0);
        checkOutput("rst_done",  32'(if8.done),    32'd0);
        checkOutput("rst_bcd",   32'(if8.bcd),     32'd0);
        checkOutput("rst_nd",    32'(if8.ndigits), 32'd1);
        checkOutput("rstw_bcd",  32'(ifw.bcd),     32'd0);
        checkOutput("rstw_nd",   32'(ifw.ndigits), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, applied back-to-back.
        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].bin, lat, busyCnt);
            checkOutput("tbl_latency", 32'(lat),         32'd9);
            checkOutput("tbl_busycnt", 32'(busyCnt),     32'd9);
            checkOutput("tbl_busy_lo", 32'(if8.busy),    32'd0);
            checkOutput("tbl_bcd",     32'(if8.bcd),     32'(vecs[i].bcd));
            checkOutput("tbl_nd",      32'(if8.ndigits), 32'(vecs[i].nd));
        end

        // Start while busy is ignored and bin changes do not leak in; then a
        // start in the done cycle is accepted straight away.
        $display("[TB] start while busy / start in done cycle");
        @(negedge clk);
        if8.start = 1'b1;
        if8.bin   = 8'd99;
        @(negedge clk);
        if8.start = 1'b0;
        n = 0;
        while (!if8.done && n < 40) begin
            if (n == 2) begin
                if8.start = 1'b1;
                if8.bin   = 8'd200;
            end
            else if (n == 3) begin
                if8.start = 1'b0;
                if8.bin   = 8'hAA;
            end
            @(negedge clk);
            n++;
        end
        checkOutput("busy_ign_latency", 32'(n),           32'd9);
        checkOutput("busy_ign_bcd",     32'(if8.bcd),     32'h099);
        checkOutput("busy_ign_nd",      32'(if8.ndigits), 32'd2);
        if8.start = 1'b1;
        if8.bin   = 8'd200;
        @(negedge clk);
        if8.start = 1'b0;
        if8.bin   = 8'd0;
        checkOutput("done_one_cycle", 32'(if8.done), 32'd0);
        checkOutput("b2b_busy",       32'(if8.busy), 32'd1);
        checkOutput("hold_bcd",       32'(if8.bcd),  32'h099);
        n = 0;
        while (!if8.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b_latency", 32'(n),           32'd9);
        checkOutput("b2b_bcd",     32'(if8.bcd),     32'h200);
        checkOutput("b2b_nd",      32'(if8.ndigits), 32'd3);

        // Reset mid-conversion aborts with no done pulse.
        $display("[TB] reset mid-conversion");
        @(negedge clk);
        if8.start = 1'b1;
        if8.bin   = 8'd123;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(if8.busy),    32'd0);
        checkOutput("abort_bcd",  32'(if8.bcd),     32'd0);
        checkOutput("abort_nd",   32'(if8.ndigits), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (20) begin
            @(negedge clk);
            if (if8.done) dn++;
        end
        checkOutput("abort_no_done", 32'(dn),       32'd0);
        checkOutput("abort_idle",    32'(if8.busy), 32'd0);
        applyStimulus(8'd123, lat, busyCnt);
        checkOutput("post_abort_latency", 32'(lat),         32'd9);
        checkOutput("post_abort_bcd",     32'(if8.bcd),     32'h123);
        checkOutput("post_abort_nd",      32'(if8.ndigits), 32'd3);

        // Wide instance: boundary values plus random values against the model.
        $display("[TB] wide instance");
        @(negedge clk);
        applyWide(16'hFFFF, lat);
        checkOutput("w_latency", 32'(lat),         32'd17);
        checkOutput("w_bcd_max", 32'(ifw.bcd),     32'h65535);
        checkOutput("w_nd_max",  32'(ifw.ndigits), 32'd5);
        @(negedge clk);
        applyWide(16'd1000, lat);
        checkOutput("w_bcd_1000", 32'(ifw.bcd),     32'h01000);
        checkOutput("w_nd_1000",  32'(ifw.ndigits), 32'd4);
        for (int i = 0; i < 16; i++) begin
            wv = 16'($urandom_range(0, 65535));
            applyWide(wv, lat);
            checkOutput("w_rand_latency", 32'(lat),         32'd17);
            checkOutput("w_rand_bcd",     32'(ifw.bcd),     refBcd(32'(wv)));
            checkOutput("w_rand_nd",      32'(ifw.ndigits), 32'(refDigits(32'(wv))));
        end

        // Every 8-bit value in shuffled order, back-to-back.
        $display("[TB] randomized full sweep");
        for (int i = 0; i < 256; i++) perm[i] = i;
        for (int i = 255; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        repeat (2) @(negedge clk);
        snap = done8Count;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'(perm[i]), lat, busyCnt);
            checkOutput("sweep_bcd", 32'(if8.bcd),     refBcd(32'(perm[i])));
            checkOutput("sweep_nd",  32'(if8.ndigits), 32'(refDigits(32'(perm[i]))));
        end
        repeat (3) @(negedge clk);
        checkOutput("sweep_done_count", 32'(done8Count - snap), 32'd256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, processing one input bit per clock.
- Successor to the combinational 8-bit/3-digit converter used ahead of the LCD digit formatter.
- Supports arbitrary input width and digit count, a start/busy/done handshake, registered outputs and a significant-digit count for leading-zero blanking on the display.
- Sits between the DHT11 data decoder (humidity/temperature bytes, or wider sums) and the LCD character driver.

Parameters:
- BIN_W, 8, input binary width in bits; legal range 1..32.
- DIGITS, 3, number of BCD output digits; must be at least ceil(BIN_W*log10(2)), otherwise elaboration fails.
- CNT_W, $clog2(BIN_W+1), bit-count width; localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request conversion of bin; sampled only when busy=0.
- bin  in  BIN_W  unsigned binary value; sampled on the accepting edge only.
- busy  out  1  conversion in progress; start is ignored while high.
- done  out  1  one-cycle pulse: bcd and ndigits hold a new result.
- bcd  out  4*DIGITS  packed BCD result; digit 0 (units) is in bits [3:0], most significant digit in the top nibble.
- ndigits  out  $clog2(DIGITS+1)  count of significant digits, from 1 to DIGITS; a value of 0 reports 1.

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, bcd=0, ndigits=1, internal shift register, BCD work register and bit counter all cleared.
- States:
  - IDLE: busy=0. If start=1, latch bin into the shift register, clear the work register, load counter=BIN_W, go to SHIFT.
  - SHIFT: busy=1. Each cycle, every work nibble >=5 gets +3 (all nibbles evaluated in parallel on pre-adjust values). Then the work register shifts left 1, taking the shift-register MSB in; the shift register shifts left; counter decrements. When counter reaches 1 (last bit), go to OUT.
  - OUT: busy=1. Copy the work register to bcd, compute ndigits, pulse done=1 on the next edge, return to IDLE.
- Timing: start accepted at edge k. Shift edges are k+1..k+BIN_W. At edge k+BIN_W+1, bcd and ndigits update, done=1 and busy=0. Start-to-done latency is BIN_W+1 cycles.
- done is high exactly one cycle and is registered, not combinational.
- Outputs bcd and ndigits hold their last result until the next done; they are not cleared by start.
- ndigits = index of the highest nonzero nibble + 1; all-zero result gives 1.
- start while busy=1: ignored, no queuing, in-flight conversion unaffected.
- start in the done cycle: accepted (state is IDLE), giving back-to-back throughput of one result per BIN_W+2 cycles.
- bin changes after acceptance: no effect on the in-flight result.
- Reset mid-conversion: abort immediately. All outputs return to reset values; no done pulse for the aborted conversion.
- Nibble add-3 is 4-bit modulo. With a legal DIGITS no carry leaves the top nibble, so no overflow flag is provided.

Test Plan:
- Defaults; reset, then bin=8'd255 with start for 1 cycle -> busy high 9 cycles, done pulse 9 cycles after the start edge, bcd=12'h255, ndigits=3.
- Defaults; bin=0 -> bcd=12'h000, ndigits=1. Then bin=7 -> bcd=12'h007, ndigits=1. Then bin=40 -> bcd=12'h040, ndigits=2.
- Defaults; start bin=99, pulse start again with bin=200 at 3 cycles after acceptance -> single done, bcd=12'h099. Then start asserted in the done cycle with bin=200 -> second done 9 cycles later, bcd=12'h200.
- Defaults; start bin=123, assert rst for 1 cycle at 4 cycles after acceptance -> busy=0, done never pulses, bcd=0, ndigits=1. Fresh start bin=123 -> bcd=12'h123.
- BIN_W=16, DIGITS=5; bin=65535 -> done 17 cycles after start, bcd=20'h65535, ndigits=5. bin=1000 -> bcd=20'h01000, ndigits=4.
- Random sweep, defaults: all 256 values back-to-back -> each bcd equals the decimal reference, done count = 256, no lost or duplicate done.
